wb_sram_ctrl: RTL and testbench
===============================

Name: wb_sram_ctrl

Overview:
Wishbone-side slave placed directly downstream of wishbone_bus. It consumes the bus master's address, write data, write enable and 16-bit device select, and returns read data and ack. It sequences multi-cycle accesses to two external asynchronous 32-bit SRAM chips (base RAM and ext RAM) that share one address, data and control bus and have separate chip enables. Reads and writes are full-word; wishbone_bus already merges partial writes by read-modify-write.

Parameters:
RD_WAIT, 2, cycles oe_n is held low per read; legal range ≥1.
WR_WAIT, 2, cycles we_n is held low per write; legal range ≥1.
ADDR_W, 20, SRAM word-address width.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-low reset (`RstEnable = 1'b0).
wb_addr_i  in  32  physical byte address from wishbone_bus (post-MMU).
wb_data_i  in  32  write data.
wb_we_i  in  1  1 = write.
wb_select_i  in  16  one-hot device select; bit0 = base RAM, bit1 = ext RAM.
wb_data_o  out  32  read data; valid while wb_ack_o = 1.
wb_ack_o  out  1  one-cycle completion pulse.
sram_addr_o  out  ADDR_W  word address, wb_addr_i[ADDR_W+1:2].
sram_data_i  in  32  data from the shared SRAM bus.
sram_data_o  out  32  data driven onto the shared SRAM bus.
sram_data_oe  out  1  1 = drive sram_data_o (tri-state control at top level).
sram_be_n  out  4  byte enables; always 4'b0000 outside reset.
base_ce_n  out  1  base RAM chip enable.
ext_ce_n  out  1  ext RAM chip enable.
sram_oe_n  out  1  output enable.
sram_we_n  out  1  write enable.

Behaviour:
- All outputs are registered Moore outputs; no combinational path from inputs to outputs.
- Reset (rst = 0 at a posedge): state IDLE; wb_ack_o = 0; wb_data_o = 0; sram_addr_o = 0; sram_data_o = 0; sram_data_oe = 0; sram_be_n = 4'b1111; base_ce_n, ext_ce_n, sram_oe_n and sram_we_n all = 1. Reset mid-access aborts the access with no ack; strobes are deasserted at that edge.
- Bus contract: the master holds addr, data, we and select stable while wb_ack_o = 0. The master may change the request in the cycle after the posedge at which it samples wb_ack_o = 1.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE, ERR. A 4-bit wait counter cnt is used.
- IDLE, decoding wb_select_i:
  - Zero: stay in IDLE.
  - Exactly bit0 or exactly bit1 set: latch the address and the selected chip. A read goes to RD with cnt = RD_WAIT-1. A write latches the data and goes to WR_SETUP.
  - Any other value (both bits set, or any bit[15:2] set): go to ERR.
- RD: selected ce_n = 0, sram_oe_n = 0, sram_data_oe = 0. cnt decrements each cycle. On the edge where cnt = 0, capture sram_data_i into wb_data_o and go to DONE. Read ack arrives RD_WAIT+1 cycles after the IDLE cycle in which the request is sampled.
- WR_SETUP (1 cycle): ce_n = 0, sram_data_oe = 1, sram_we_n = 1. Load cnt = WR_WAIT-1.
- WR_PULSE: sram_we_n = 0 for WR_WAIT cycles; then go to WR_HOLD.
- WR_HOLD (1 cycle): sram_we_n = 1, data still driven, ce_n = 0; then go to DONE. Write ack arrives WR_WAIT+3 cycles after the request cycle.
- DONE (1 cycle): wb_ack_o = 1. All strobes deasserted, sram_data_oe = 0. wb_data_o holds the read data, or the prior value for writes. Next state is IDLE.
- ERR (1 cycle): wb_ack_o = 1, wb_data_o = 0, no SRAM strobe. Next state is IDLE; the block never hangs.
- In IDLE and DONE, wb_ack_o = 0 except as stated above. sram_data_oe and sram_oe_n = 0 are never asserted in the same cycle.
- Back-to-back accesses: the minimum period is RD_WAIT+2 cycles for reads and WR_WAIT+4 cycles for writes.

Decomposition:
- Add to defines.v:
  - `SRAM_SEL_BASE (16'h0001) and `SRAM_SEL_EXT (16'h0002);
  - state encodings `SRAM_IDLE .. `SRAM_ERR (3 bits);
  - `SRAM_ADDR_W.
- Reuse the existing `RstEnable, `ZeroWord, `WriteEnable and `True_v.
- Single module; no sub-module is warranted.

Test Plan:
1. Reset held 3 cycles during a read in RD → strobes all 1 at the reset edge; no wb_ack_o; wb_data_o = 0; IDLE after release.
2. Read base RAM: addr 32'h0000_0010, sel 16'h0001, SRAM model returns 32'hDEADBEEF → sram_addr_o = 20'h00004; base_ce_n = 0 and sram_oe_n = 0 for 2 cycles; wb_ack_o = 1 with wb_data_o = 32'hDEADBEEF exactly 3 cycles after the request cycle.
3. Write ext RAM: addr 32'h0000_0FFC, data 32'h12345678, sel 16'h0002 → ext_ce_n = 0; sram_we_n low for exactly 2 cycles, framed by one setup and one hold cycle with sram_data_oe = 1; ack 5 cycles after the request; the model holds 32'h12345678 at word 20'h003FF.
4. Illegal select 16'h0003, then 16'h0100 → each gives a 1-cycle ERR ack with wb_data_o = 0 and no ce_n activity.
5. Back-to-back read, write, read with RD_WAIT = 1 and WR_WAIT = 3 → acks at the computed cycles; no overlap of sram_data_oe with sram_oe_n = 0; the second read returns the just-written data.

Source files
------------

// File: rtl/wb_sram_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-asynchronous-SRAM controller:
// device select codes, state encoding and select decoding.
package wb_sram_ctrl_pkg;

    localparam logic [15:0] SRAM_SEL_BASE = 16'h0001;
    localparam logic [15:0] SRAM_SEL_EXT  = 16'h0002;
    localparam logic [15:0] SRAM_SEL_NONE = 16'h0000;
    localparam int          SRAM_ADDR_W   = 20;

    localparam logic        RST_ENABLE    = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        TRUE_V        = 1'b1;

    typedef enum logic [2:0] {
        SRAM_IDLE     = 3'd0,
        SRAM_RD       = 3'd1,
        SRAM_WR_SETUP = 3'd2,
        SRAM_WR_PULSE = 3'd3,
        SRAM_WR_HOLD  = 3'd4,
        SRAM_DONE     = 3'd5,
        SRAM_ERR      = 3'd6
    } sram_state_e;

    typedef enum logic [1:0] {
        SEL_NONE    = 2'd0,
        SEL_BASE    = 2'd1,
        SEL_EXT     = 2'd2,
        SEL_ILLEGAL = 2'd3
    } sel_kind_e;

    // Classify the one-hot device select: only a lone bit0 or a lone bit1
    // addresses an SRAM chip; anything else non-zero is an illegal request.
    function automatic sel_kind_e decode_select(input logic [15:0] sel);
        sel_kind_e kind;
        case (sel)
            SRAM_SEL_NONE: kind = SEL_NONE;
            SRAM_SEL_BASE: kind = SEL_BASE;
            SRAM_SEL_EXT:  kind = SEL_EXT;
            default:       kind = SEL_ILLEGAL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone slave sequencing full-word accesses to two asynchronous 32-bit
// SRAM chips (base and ext) sharing one address/data/control bus.
// Every output is a register; the next-cycle output values are computed
// together with the next state so the outputs behave as Moore outputs.
module wb_sram_ctrl
    import wb_sram_ctrl_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int ADDR_W  = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_addr_i,
    input  logic [31:0]       wb_data_i,
    input  logic              wb_we_i,
    input  logic [15:0]       wb_select_i,
    output logic [31:0]       wb_data_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [31:0]       sram_data_i,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe,
    output logic [3:0]        sram_be_n,
    output logic              base_ce_n,
    output logic              ext_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [3:0] RD_CNT_INIT = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_WAIT - 1);

    sram_state_e state_r;
    logic [3:0]  cnt_r;
    sel_kind_e   sel_kind_s;
    logic        unused_addr_s;

    assign sel_kind_s    = decode_select(wb_select_i);
    // Byte-offset and above-window address bits do not reach the SRAM.
    assign unused_addr_s = ^{wb_addr_i[31:ADDR_W+2], wb_addr_i[1:0]};

    // Access sequencer: state, wait counter and all registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r      <= SRAM_IDLE;
            cnt_r        <= 4'd0;
            wb_ack_o     <= 1'b0;
            wb_data_o    <= ZERO_WORD;
            sram_addr_o  <= {ADDR_W{1'b0}};
            sram_data_o  <= ZERO_WORD;
            sram_data_oe <= 1'b0;
            sram_be_n    <= 4'b1111;
            base_ce_n    <= 1'b1;
            ext_ce_n     <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
        end else begin
            sram_be_n <= 4'b0000;
            wb_ack_o  <= 1'b0;
            case (state_r)
                SRAM_IDLE: begin
                    case (sel_kind_s)
                        SEL_BASE, SEL_EXT: begin
                            sram_addr_o <= wb_addr_i[ADDR_W+1:2];
                            base_ce_n   <= (sel_kind_s == SEL_BASE) ? 1'b0 : 1'b1;
                            ext_ce_n    <= (sel_kind_s == SEL_EXT)  ? 1'b0 : 1'b1;
                            if (wb_we_i == WRITE_ENABLE) begin
                                sram_data_o  <= wb_data_i;
                                sram_data_oe <= 1'b1;
                                state_r      <= SRAM_WR_SETUP;
                            end else begin
                                sram_oe_n <= 1'b0;
                                cnt_r     <= RD_CNT_INIT;
                                state_r   <= SRAM_RD;
                            end
                        end
                        SEL_ILLEGAL: begin
                            wb_ack_o  <= 1'b1;
                            wb_data_o <= ZERO_WORD;
                            state_r   <= SRAM_ERR;
                        end
                        default: begin
                            state_r <= SRAM_IDLE;
                        end
                    endcase
                end
                SRAM_RD: begin
                    if (cnt_r == 4'd0) begin
                        wb_data_o <= sram_data_i;
                        wb_ack_o  <= 1'b1;
                        base_ce_n <= 1'b1;
                        ext_ce_n  <= 1'b1;
                        sram_oe_n <= 1'b1;
                        state_r   <= SRAM_DONE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                SRAM_WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    cnt_r     <= WR_CNT_INIT;
                    state_r   <= SRAM_WR_PULSE;
                end
                SRAM_WR_PULSE: begin
                    if (cnt_r == 4'd0) begin
                        sram_we_n <= 1'b1;
                        state_r   <= SRAM_WR_HOLD;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                SRAM_WR_HOLD: begin
                    base_ce_n    <= 1'b1;
                    ext_ce_n     <= 1'b1;
                    sram_data_oe <= 1'b0;
                    wb_ack_o     <= 1'b1;
                    state_r      <= SRAM_DONE;
                end
                SRAM_DONE: begin
                    state_r <= SRAM_IDLE;
                end
                SRAM_ERR: begin
                    state_r <= SRAM_IDLE;
                end
                default: begin
                    base_ce_n    <= 1'b1;
                    ext_ce_n     <= 1'b1;
                    sram_oe_n    <= 1'b1;
                    sram_we_n    <= 1'b1;
                    sram_data_oe <= 1'b0;
                    state_r      <= SRAM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: two instances (RD_WAIT/WR_WAIT = 2/2 and 1/3),
// a transaction-level reference model, a per-cycle compare process and a
// few hand-computed expectations.
module tb_wb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_addr  [2];
    logic [31:0] wb_wdata [2];
    logic        wb_we    [2];
    logic [15:0] wb_sel   [2];
    logic [31:0] wb_rdata [2];
    logic        wb_ack   [2];
    logic [19:0] sram_addr[2];
    logic [31:0] sram_din [2];
    logic [31:0] sram_dout[2];
    logic        sram_doe [2];
    logic [3:0]  be_n     [2];
    logic        base_ce_n[2];
    logic        ext_ce_n [2];
    logic        oe_n     [2];
    logic        we_n     [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_sram_ctrl #(
            .RD_WAIT((g == 0) ? 2 : 1),
            .WR_WAIT((g == 0) ? 2 : 3),
            .ADDR_W (20)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .wb_addr_i   (wb_addr[g]),
            .wb_data_i   (wb_wdata[g]),
            .wb_we_i     (wb_we[g]),
            .wb_select_i (wb_sel[g]),
            .wb_data_o   (wb_rdata[g]),
            .wb_ack_o    (wb_ack[g]),
            .sram_addr_o (sram_addr[g]),
            .sram_data_i (sram_din[g]),
            .sram_data_o (sram_dout[g]),
            .sram_data_oe(sram_doe[g]),
            .sram_be_n   (be_n[g]),
            .base_ce_n   (base_ce_n[g]),
            .ext_ce_n    (ext_ce_n[g]),
            .sram_oe_n   (oe_n[g]),
            .sram_we_n   (we_n[g])
        );
    end

    function automatic int rd_wait(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int wr_wait(input int i);
        return (i == 0) ? 2 : 3;
    endfunction
    function automatic logic [31:0] init_word(input int i, input int c, input int a);
        return 32'(i * 7919 + c * 104729 + a + 1) * 32'h9E37_79B9;
    endfunction

    // Device memories (written by DUT strobes) and reference memories (written by the model).
    logic [31:0] dev_mem [2][2][1024];
    logic [31:0] ref_mem [2][2][1024];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Asynchronous SRAM: drives data while exactly one chip and oe_n are low.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (!oe_n[i] && (base_ce_n[i] != ext_ce_n[i]))
                sram_din[i] = dev_mem[i][ext_ce_n[i] ? 0 : 1][sram_addr[i][9:0]];
            else
                sram_din[i] = 32'hBAD0_BAD0;
        end
    end

    // Reference model state: one outstanding transaction per instance,
    // described by its kind and the number of cycles since acceptance.
    bit          model_valid = 1'b0;
    bit          m_busy  [2];
    int          m_kind  [2];   // 0 read, 1 write, 2 error
    int          m_k     [2];
    int          m_len   [2];
    int          m_chip  [2];
    logic [31:0] m_rval  [2];
    logic [31:0] m_rdata [2];
    logic [19:0] m_addr  [2];
    logic [31:0] m_dout  [2];
    bit          m_rst   [2];

    initial begin
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 1024; a++) begin
                    dev_mem[i][c][a] = init_word(i, c, a);
                    ref_mem[i][c][a] = init_word(i, c, a);
                end
        dev_mem[0][0][4] = 32'hDEAD_BEEF;
        ref_mem[0][0][4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_rst[i] = 1'b1;
            m_rdata[i] = 32'h0; m_addr[i] = 20'h0; m_dout[i] = 32'h0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!we_n[i] && (base_ce_n[i] != ext_ce_n[i]))
                    dev_mem[i][ext_ce_n[i] ? 0 : 1][sram_addr[i][9:0]] = sram_dout[i];
                if (rst == 1'b0) begin
                    m_busy[i] = 1'b0; m_rst[i] = 1'b1;
                    m_rdata[i] = 32'h0; m_addr[i] = 20'h0; m_dout[i] = 32'h0;
                end else begin
                    m_rst[i] = 1'b0;
                    if (m_busy[i] && m_k[i] == m_len[i]) begin
                        m_busy[i] = 1'b0;
                    end else if (m_busy[i]) begin
                        m_k[i]++;
                    end else if (wb_sel[i] != 16'h0) begin
                        m_busy[i] = 1'b1;
                        m_k[i] = 1;
                        if (wb_sel[i] == 16'h0001 || wb_sel[i] == 16'h0002) begin
                            m_chip[i] = (wb_sel[i] == 16'h0002) ? 1 : 0;
                            m_addr[i] = wb_addr[i][21:2];
                            if (wb_we[i]) begin
                                m_kind[i] = 1;
                                m_len[i]  = wr_wait(i) + 3;
                                m_dout[i] = wb_wdata[i];
                                ref_mem[i][m_chip[i]][wb_addr[i][11:2]] = wb_wdata[i];
                            end else begin
                                m_kind[i] = 0;
                                m_len[i]  = rd_wait(i) + 1;
                                m_rval[i] = ref_mem[i][m_chip[i]][wb_addr[i][11:2]];
                            end
                        end else begin
                            m_kind[i] = 2;
                            m_len[i]  = 1;
                        end
                    end
                    if (m_busy[i] && m_k[i] == m_len[i]) begin
                        if (m_kind[i] == 0) m_rdata[i] = m_rval[i];
                        if (m_kind[i] == 2) m_rdata[i] = 32'h0;
                    end
                end
            end
            if (rst == 1'b0) model_valid = 1'b1;
        end
    end

    int oe_low_cnt[2] = '{0, 0};
    int we_low_cnt[2] = '{0, 0};
    int ce_low_cnt[2] = '{0, 0};

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                for (int i = 0; i < 2; i++) begin
                    logic e_bce, e_ece, e_oe, e_we, e_doe, e_ack;
                    int   k;
                    e_bce = 1'b1; e_ece = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_doe = 1'b0; e_ack = 1'b0;
                    k = m_k[i];
                    if (m_busy[i]) begin
                        if (m_kind[i] == 0) begin
                            if (k <= rd_wait(i)) begin
                                e_oe = 1'b0;
                                if (m_chip[i] == 0) e_bce = 1'b0; else e_ece = 1'b0;
                            end else e_ack = 1'b1;
                        end else if (m_kind[i] == 1) begin
                            if (k <= wr_wait(i) + 2) begin
                                e_doe = 1'b1;
                                if (m_chip[i] == 0) e_bce = 1'b0; else e_ece = 1'b0;
                            end else e_ack = 1'b1;
                            if (k >= 2 && k <= wr_wait(i) + 1) e_we = 1'b0;
                        end else e_ack = 1'b1;
                    end
                    chk("ack", i, 32'(wb_ack[i]), 32'(e_ack));
                    chk("rdata", i, wb_rdata[i], m_rdata[i]);
                    chk("sram_addr", i, 32'(sram_addr[i]), 32'(m_addr[i]));
                    chk("sram_dout", i, sram_dout[i], m_dout[i]);
                    chk("data_oe", i, 32'(sram_doe[i]), 32'(e_doe));
                    chk("be_n", i, 32'(be_n[i]), m_rst[i] ? 32'hF : 32'h0);
                    chk("base_ce_n", i, 32'(base_ce_n[i]), 32'(e_bce));
                    chk("ext_ce_n", i, 32'(ext_ce_n[i]), 32'(e_ece));
                    chk("oe_n", i, 32'(oe_n[i]), 32'(e_oe));
                    chk("we_n", i, 32'(we_n[i]), 32'(e_we));
                    chk("oe_overlap", i, 32'(sram_doe[i] & ~oe_n[i]), 32'h0);
                    if (!oe_n[i]) oe_low_cnt[i]++;
                    if (!we_n[i]) we_low_cnt[i]++;
                    if (!base_ce_n[i] || !ext_ce_n[i]) ce_low_cnt[i]++;
                end
            end
        end
    end

    // One bus transaction, honouring the hold-until-ack contract.
    task automatic xact(input int i, input logic [15:0] sel, input logic we,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int lat, output logic [31:0] rd);
        wb_sel[i] = sel; wb_we[i] = we; wb_addr[i] = addr; wb_wdata[i] = data;
        lat = 0;
        rd  = 32'h0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (wb_ack[i]) begin
                rd = wb_rdata[i];
                break;
            end
            if (lat > 40) begin
                chk("ack_timeout", i, 32'h0, 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        wb_sel[i] = 16'h0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        int          oe0, we0, ce0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wb_sel[i] = 16'h0; wb_we[i] = 1'b0; wb_addr[i] = 32'h0; wb_wdata[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_be_n", 0, 32'(be_n[0]), 32'hF);
        chk("reset_rdata", 1, wb_rdata[1], 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Read base RAM word 4.
        oe0 = oe_low_cnt[0]; ce0 = ce_low_cnt[0];
        xact(0, 16'h0001, 1'b0, 32'h0000_0010, 32'h0, lat, rd);
        chk("rd_latency", 0, 32'(lat), 32'd3);
        chk("rd_data", 0, rd, 32'hDEAD_BEEF);
        chk("rd_oe_cycles", 0, 32'(oe_low_cnt[0] - oe0), 32'd2);
        chk("rd_ce_cycles", 0, 32'(ce_low_cnt[0] - ce0), 32'd2);

        // Write ext RAM word 0x3FF.
        we0 = we_low_cnt[0]; ce0 = ce_low_cnt[0];
        xact(0, 16'h0002, 1'b1, 32'h0000_0FFC, 32'h1234_5678, lat, rd);
        chk("wr_latency", 0, 32'(lat), 32'd5);
        chk("wr_we_cycles", 0, 32'(we_low_cnt[0] - we0), 32'd2);
        chk("wr_ce_cycles", 0, 32'(ce_low_cnt[0] - ce0), 32'd4);
        chk("wr_mem", 0, dev_mem[0][1][10'h3FF], 32'h1234_5678);

        // Illegal selects.
        ce0 = ce_low_cnt[0];
        xact(0, 16'h0003, 1'b0, 32'h0000_0020, 32'h0, lat, rd);
        chk("err3_latency", 0, 32'(lat), 32'd1);
        chk("err3_data", 0, rd, 32'h0);
        xact(0, 16'h0100, 1'b1, 32'h0000_0024, 32'hFFFF_FFFF, lat, rd);
        chk("err100_latency", 0, 32'(lat), 32'd1);
        chk("err100_data", 0, rd, 32'h0);
        chk("err_ce_cycles", 0, 32'(ce_low_cnt[0] - ce0), 32'd0);

        // Reset in the middle of a read.
        xact(0, 16'h0001, 1'b0, 32'h0000_0010, 32'h0, lat, rd);
        wb_sel[0] = 16'h0001; wb_we[0] = 1'b0; wb_addr[0] = 32'h0000_0040;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; wb_sel[0] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oe_n", 0, 32'(oe_n[0]), 32'h1);
        chk("rst_base_ce_n", 0, 32'(base_ce_n[0]), 32'h1);
        chk("rst_ack", 0, 32'(wb_ack[0]), 32'h0);
        chk("rst_rdata", 0, wb_rdata[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        xact(0, 16'h0001, 1'b0, 32'h0000_0010, 32'h0, lat, rd);
        chk("post_rst_latency", 0, 32'(lat), 32'd3);
        chk("post_rst_data", 0, rd, 32'hDEAD_BEEF);

        // Back-to-back read, write, read on the RD_WAIT=1 / WR_WAIT=3 instance.
        xact(1, 16'h0001, 1'b0, 32'h0000_0100, 32'h0, lat, rd);
        chk("b2b_rd1_latency", 1, 32'(lat), 32'd2);
        xact(1, 16'h0001, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, lat, rd);
        chk("b2b_wr_latency", 1, 32'(lat), 32'd6);
        xact(1, 16'h0001, 1'b0, 32'h0000_0100, 32'h0, lat, rd);
        chk("b2b_rd2_latency", 1, 32'(lat), 32'd2);
        chk("b2b_rd2_data", 1, rd, 32'hCAFE_F00D);

        // Randomized traffic on both instances.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 60; n++) begin
                logic [15:0] sel;
                logic [31:0] addr;
                int          r;
                r = $urandom_range(0, 9);
                if (r < 4)       sel = 16'h0001;
                else if (r < 8)  sel = 16'h0002;
                else if (r == 8) sel = 16'h0003;
                else             sel = 16'h0001 << $urandom_range(2, 15);
                addr = $urandom();
                addr[21:8] = 14'h0;
                xact(i, sel, 1'($urandom_range(0, 1)), addr, $urandom(), lat, rd);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
